// File: rtl/pwlock_sequencer_if.sv
// pwlock_sequencer_if
// Keypad, admin and validator signals of the password-lock sequencer.
// slave: the sequencer side. master: the surrounding board (keypad, admin, validator).
interface pwlock_sequencer_if;
  // Keypad and control
  logic       key_valid;
  logic [3:0] key_digit;
  logic       prog_req;
  logic       admin_clear;
  // Validator side
  logic [1:0] val_address;
  logic [3:0] val_data;
  logic [3:0] val_digit;
  logic       val_enable;
  logic       val_rst_n;
  logic       val_reset_lockdown;
  logic       val_error;
  logic       val_unlock;
  logic       val_lockdown;
  // Status
  logic       busy;
  logic       unlocked;
  logic       locked_out;
  logic       prog_done;

  modport slave (
    input  key_valid, key_digit, prog_req, admin_clear,
    input  val_address, val_error, val_unlock, val_lockdown,
    output val_data, val_digit, val_enable, val_rst_n, val_reset_lockdown,
    output busy, unlocked, locked_out, prog_done
  );

  modport master (
    output key_valid, key_digit, prog_req, admin_clear,
    output val_address, val_error, val_unlock, val_lockdown,
    input  val_data, val_digit, val_enable, val_rst_n, val_reset_lockdown,
    input  busy, unlocked, locked_out, prog_done
  );
endinterface

// File: rtl/pwlock_sequencer.sv
// pwlock_sequencer
// Sequencer between the debounced keypad and the serial password validator. Holds the
// 4-digit password (read by the validator through val_address/val_data), runs program
// and verify sessions with one validator enable per keyed digit, and recovers from lockdown.
// Optional feature macro: PWSEQ_LOCKOUT_TIMER_EN -- when defined, lockdown also ends by
// itself LOCKOUT_CYCLES cycles after entry; admin_clear works in both builds.
module pwlock_sequencer #(
  parameter logic [15:0] INIT_PW        = 16'h0000,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input logic               CLK,
  input logic               RST,
  pwlock_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StProg, StArm, StWaitKey, StStep, StCheck, StOpen, StLocked
  } state_e;

  state_e      r_state, w_state_d;

  // Password register file and program-session shadow (digits 0..2; digit 3 arrives last)
  logic [15:0] r_rf, w_rf_d;
  logic [11:0] r_shadow, w_shadow_d;
  logic [1:0]  r_count, w_count_d;
  logic [3:0]  r_pend, w_pend_d;

  // Registered outputs
  logic [3:0]  r_val_digit, w_val_digit_d;
  logic        r_val_enable, w_val_enable_d;
  logic        r_val_rst_n, w_val_rst_n_d;
  logic        r_val_reset_lockdown, w_val_reset_lockdown_d;
  logic        r_busy, w_busy_d;
  logic        r_unlocked, w_unlocked_d;
  logic        r_locked_out, w_locked_out_d;
  logic        r_prog_done, w_prog_done_d;

  // Transition strobes shared between next-state and output logic
  logic        w_close;
  logic        w_exit_lock;
  logic        w_commit;
  logic        w_lock_seen;
  logic        w_timer_exp;

  // The validator drops lockDown only after it has seen the clear pulse, so the stale
  // level during the pulse cycle must not send us straight back into LOCKED.
  assign w_lock_seen = bus.val_lockdown && !r_val_reset_lockdown;

`ifdef PWSEQ_LOCKOUT_TIMER_EN
  localparam int unsigned CntW = $clog2(LOCKOUT_CYCLES);
  localparam logic [CntW-1:0] LoadVal = CntW'(LOCKOUT_CYCLES - 1);

  logic [CntW-1:0] r_lock_cnt, w_lock_cnt_d;

  assign w_timer_exp = (r_state == StLocked) && (r_lock_cnt == '0);

  // Lockout timer: load on entry to LOCKED, count down to zero while held there.
  always_comb begin
    w_lock_cnt_d = r_lock_cnt;
    if ((r_state != StLocked) && (w_state_d == StLocked)) begin
      w_lock_cnt_d = LoadVal;
    end else if ((r_state == StLocked) && (r_lock_cnt != '0)) begin
      w_lock_cnt_d = r_lock_cnt - CntW'(1);
    end
  end

  // Lockout timer register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lock_cnt <= '0;
    end else begin
      r_lock_cnt <= w_lock_cnt_d;
    end
  end
`else
  // Without the timer the hold time is irrelevant; keep the parameter referenced.
  logic w_unused_lockout_cfg;
  assign w_unused_lockout_cfg = ^LOCKOUT_CYCLES;
  assign w_timer_exp = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= StIdle;
      r_rf     <= INIT_PW;
      r_shadow <= '0;
      r_count  <= '0;
      r_pend   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_rf     <= w_rf_d;
      r_shadow <= w_shadow_d;
      r_count  <= w_count_d;
      r_pend   <= w_pend_d;
    end
  end

  // Next-state logic, including the program shadow and the one-cycle commit.
  always_comb begin
    w_state_d   = r_state;
    w_rf_d      = r_rf;
    w_shadow_d  = r_shadow;
    w_count_d   = r_count;
    w_pend_d    = r_pend;
    w_close     = 1'b0;
    w_exit_lock = 1'b0;
    w_commit    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_lock_seen) begin
          w_state_d = StLocked;
        end else if (bus.key_valid) begin
          if (bus.prog_req) begin
            w_shadow_d[3:0] = bus.key_digit;
            w_count_d       = 2'd1;
            w_state_d       = StProg;
          end else begin
            w_pend_d  = bus.key_digit;
            w_state_d = StArm;
          end
        end
      end

      StProg: begin
        if (bus.val_lockdown) begin
          // Abandon the session; the register file keeps the old password.
          w_count_d = 2'd0;
          w_state_d = StLocked;
        end else if (bus.key_valid) begin
          if (r_count == 2'd3) begin
            w_rf_d    = {bus.key_digit, r_shadow};
            w_commit  = 1'b1;
            w_count_d = 2'd0;
            w_state_d = StIdle;
          end else begin
            if (r_count == 2'd2) begin
              w_shadow_d[11:8] = bus.key_digit;
            end else if (r_count == 2'd1) begin
              w_shadow_d[7:4] = bus.key_digit;
            end else begin
              w_shadow_d[3:0] = bus.key_digit;
            end
            w_count_d = r_count + 2'd1;
          end
        end
      end

      StArm: w_state_d = StStep;

      StStep: w_state_d = StCheck;

      StCheck: begin
        if (bus.val_lockdown) begin
          w_state_d = StLocked;
        end else if (bus.val_error) begin
          w_state_d = StIdle;
        end else if (bus.val_unlock) begin
          w_state_d = StOpen;
        end else begin
          w_state_d = StWaitKey;
        end
      end

      StWaitKey: begin
        if (bus.key_valid) begin
          w_pend_d  = bus.key_digit;
          w_state_d = StStep;
        end
      end

      StOpen: begin
        if (bus.val_lockdown) begin
          w_state_d = StLocked;
        end else if (bus.key_valid) begin
          // The closing key is discarded; it only resets the validator.
          w_close   = 1'b1;
          w_state_d = StIdle;
        end
      end

      StLocked: begin
        // admin_clear and timer expiry in the same cycle still yield a single exit.
        if (bus.admin_clear || w_timer_exp) begin
          w_exit_lock = 1'b1;
          w_state_d   = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  // Output next values: outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_val_enable_d         = (w_state_d == StArm) || (w_state_d == StStep) || w_exit_lock;
    w_val_rst_n_d          = !((w_state_d == StArm) || w_close);
    w_val_reset_lockdown_d = w_exit_lock;
    w_val_digit_d          = (w_state_d == StStep) ? w_pend_d : r_val_digit;
    w_busy_d               = w_state_d inside {StProg, StArm, StWaitKey, StStep, StCheck};
    w_unlocked_d           = (w_state_d == StOpen);
    w_locked_out_d         = (w_state_d == StLocked);
    w_prog_done_d          = w_commit;
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_val_digit          <= 4'h0;
      r_val_enable         <= 1'b0;
      r_val_rst_n          <= 1'b1;
      r_val_reset_lockdown <= 1'b0;
      r_busy               <= 1'b0;
      r_unlocked           <= 1'b0;
      r_locked_out         <= 1'b0;
      r_prog_done          <= 1'b0;
    end else begin
      r_val_digit          <= w_val_digit_d;
      r_val_enable         <= w_val_enable_d;
      r_val_rst_n          <= w_val_rst_n_d;
      r_val_reset_lockdown <= w_val_reset_lockdown_d;
      r_busy               <= w_busy_d;
      r_unlocked           <= w_unlocked_d;
      r_locked_out         <= w_locked_out_d;
      r_prog_done          <= w_prog_done_d;
    end
  end

  assign bus.val_data           = r_rf[{bus.val_address, 2'b00} +: 4];
  assign bus.val_digit          = r_val_digit;
  assign bus.val_enable         = r_val_enable;
  assign bus.val_rst_n          = r_val_rst_n;
  assign bus.val_reset_lockdown = r_val_reset_lockdown;
  assign bus.busy               = r_busy;
  assign bus.unlocked           = r_unlocked;
  assign bus.locked_out         = r_locked_out;
  assign bus.prog_done          = r_prog_done;

endmodule
